// File: rtl/bpsk_symbol_demod_if.sv
// Sample/sync inputs and decided-bit/frame outputs of the BPSK symbol demodulator.
interface bpsk_symbol_demod_if #(
    parameter int DATA_WIDTH     = 8,
    parameter int PAYLOAD_LENGTH = 8
);
    logic [DATA_WIDTH-1:0]     signal;
    logic                      sync;
    logic                      bit_out;
    logic                      bit_valid;
    logic [PAYLOAD_LENGTH-1:0] data_out;
    logic                      frame_done;
    logic                      busy;

    modport master (
        output signal, sync,
        input  bit_out, bit_valid, data_out, frame_done, busy
    );

    modport slave (
        input  signal, sync,
        output bit_out, bit_valid, data_out, frame_done, busy
    );
endinterface

// File: rtl/bpsk_symbol_demod.sv
// BPSK demodulator: correlates each symbol against a square reference and
// assembles PAYLOAD_LENGTH decided bits into a frame after a sync pulse.
module bpsk_symbol_demod #(
    parameter int DATA_WIDTH     = 8,
    parameter int AMPLITUDE      = 128,
    parameter int WAVELENGTH     = 4,
    parameter int PAYLOAD_LENGTH = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    bpsk_symbol_demod_if.slave  bus
);
    localparam int KW    = $clog2(WAVELENGTH);
    localparam int ACC_W = DATA_WIDTH + 1 + KW;
    localparam int BW    = (PAYLOAD_LENGTH > 1) ? $clog2(PAYLOAD_LENGTH) : 1;

    localparam logic [KW-1:0]         HALF   = KW'(WAVELENGTH / 2);
    localparam logic [KW-1:0]         K_LAST = KW'(WAVELENGTH - 1);
    localparam logic [BW-1:0]         B_LAST = BW'(PAYLOAD_LENGTH - 1);
    localparam logic [DATA_WIDTH:0]   AMP_V  = (DATA_WIDTH + 1)'(AMPLITUDE);

    typedef enum logic [1:0] {IDLE, DEMOD, DONE} state_t;

    state_t                      state, state_nxt;
    logic signed [DATA_WIDTH:0]  c;
    logic signed [ACC_W-1:0]     c_ext, acc, acc_nxt;
    logic [KW-1:0]               k;
    logic [BW-1:0]               bit_cnt;
    logic [PAYLOAD_LENGTH-1:0]   shreg, shift_nxt, data_q;
    logic                        sym_end, last_bit, bit_dec;
    logic                        bit_out_q, bit_valid_q, frame_done_q;

    assign c       = $signed({1'b0, bus.signal}) - $signed(AMP_V);
    assign c_ext   = ACC_W'(c);
    // Square reference: first half-period adds, second half subtracts.
    assign acc_nxt = (k < HALF) ? acc + c_ext : acc - c_ext;
    assign sym_end = (state == DEMOD) && (k == K_LAST);
    assign last_bit = (bit_cnt == B_LAST);
    // Strictly positive decides 1; zero correlation decides 0.
    assign bit_dec  = !acc_nxt[ACC_W-1] && (acc_nxt != '0);
    assign shift_nxt = (shreg << 1) | PAYLOAD_LENGTH'(bit_dec);

    always_ff @(posedge clk) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (bus.sync)              state_nxt = DEMOD;
            DEMOD:   if (sym_end && last_bit)   state_nxt = DONE;
            DONE:    if (!bus.sync)             state_nxt = IDLE;
            default:                            state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            acc          <= '0;
            k            <= '0;
            bit_cnt      <= '0;
            shreg        <= '0;
            data_q       <= '0;
            bit_out_q    <= 1'b0;
            bit_valid_q  <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            bit_valid_q  <= 1'b0;
            frame_done_q <= 1'b0;
            if (state == DEMOD) begin
                if (sym_end) begin
                    acc         <= '0;
                    k           <= '0;
                    bit_out_q   <= bit_dec;
                    bit_valid_q <= 1'b1;
                    shreg       <= shift_nxt;
                    if (last_bit) begin
                        bit_cnt      <= '0;
                        data_q       <= shift_nxt;
                        frame_done_q <= 1'b1;
                    end else begin
                        bit_cnt <= bit_cnt + BW'(1);
                    end
                end else begin
                    acc <= acc_nxt;
                    k   <= k + KW'(1);
                end
            end
        end
    end

    assign bus.bit_out    = bit_out_q;
    assign bus.bit_valid  = bit_valid_q;
    assign bus.data_out   = data_q;
    assign bus.frame_done = frame_done_q;
    assign bus.busy       = (state == DEMOD);
endmodule

// File: tb/tb_bpsk_symbol_demod.sv
// Directed bench for bpsk_symbol_demod with a per-cycle frame-level reference model.
module tb_bpsk_symbol_demod;
    localparam int DW = 8, AMP = 128, W = 4, PL = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    bpsk_symbol_demod_if #(.DATA_WIDTH(DW), .PAYLOAD_LENGTH(PL)) bus ();

    bpsk_symbol_demod #(
        .DATA_WIDTH(DW), .AMPLITUDE(AMP), .WAVELENGTH(W), .PAYLOAD_LENGTH(PL)
    ) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus)
    );

    int n_checks = 0, n_fail = 0, edge_n = 0;

    // Reference model state
    bit          m_live = 0, running = 0, armed = 1;
    int          q[$];
    int          nbits, s;
    logic [PL-1:0] m_bits, m_data;
    logic        m_bit_out, m_valid, m_done, m_busy;

    // Observed pulse log, checked against literal expectations
    int   valid_cyc[$];
    int   obs_bits[$];
    int   done_cyc[$];
    int   t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (edge %0d)", name, act, exp, edge_n);
        end
    endtask

    initial forever begin
        @(posedge clk);
        edge_n++;
        if (!rst_n) begin
            m_live = 1; running = 0; armed = 1; q.delete(); nbits = 0;
            m_bits = '0; m_data = '0; m_bit_out = 0; m_valid = 0; m_done = 0;
        end else begin
            m_valid = 0; m_done = 0;
            if (running) begin
                q.push_back(int'(bus.signal) - AMP);
                if (q.size() == W) begin
                    s = 0;
                    for (int i = 0; i < W; i++) s += (i < W/2) ? q[i] : -q[i];
                    m_bit_out = (s > 0);
                    m_valid = 1;
                    m_bits = {m_bits[PL-2:0], m_bit_out};
                    q.delete();
                    nbits++;
                    if (nbits == PL) begin
                        m_data = m_bits; m_done = 1; running = 0; armed = 0;
                    end
                end
            end else if (armed && bus.sync) begin
                running = 1; nbits = 0; q.delete();
            end else if (!armed && !bus.sync) begin
                armed = 1;
            end
        end
        m_busy = running;
        #1;
        if (m_live) begin
            check("bit_valid",  bus.bit_valid,  m_valid);
            check("frame_done", bus.frame_done, m_done);
            check("busy",       bus.busy,       m_busy);
            check("bit_out",    bus.bit_out,    m_bit_out);
            check("data_out",   bus.data_out,   m_data);
            if (bus.bit_valid === 1'b1) begin
                valid_cyc.push_back(edge_n + 1);
                obs_bits.push_back(int'(bus.bit_out));
            end
            if (bus.frame_done === 1'b1) done_cyc.push_back(edge_n + 1);
        end
    end

    task automatic drive(input logic sy, input int smp);
        @(negedge clk);
        bus.sync   = sy;
        bus.signal = DW'(smp);
    endtask

    task automatic drive_sym(input logic sy, input int a, input int b, input int c, input int d);
        drive(sy, a); drive(sy, b); drive(sy, c); drive(sy, d);
    endtask

    task automatic idle(input logic sy, input int n);
        for (int i = 0; i < n; i++) drive(sy, AMP);
    endtask

    task automatic clear_log();
        valid_cyc.delete(); obs_bits.delete(); done_cyc.delete();
    endtask

    task automatic check_frame(input string tag, input int tt, input logic [PL-1:0] exp_data);
        check({tag, " n_valid"}, valid_cyc.size(), PL);
        for (int i = 0; i < PL && i < valid_cyc.size(); i++) begin
            check({tag, " valid_cyc"}, valid_cyc[i], tt + 1 + (i + 1) * W);
            check({tag, " bit"}, obs_bits[i], int'(exp_data[PL-1-i]));
        end
        check({tag, " n_done"}, done_cyc.size(), 1);
        if (done_cyc.size() > 0) check({tag, " done_cyc"}, done_cyc[0], tt + 1 + PL * W);
        check({tag, " data_out"}, bus.data_out, exp_data);
    endtask

    initial begin
        bus.sync = 1'b0;
        bus.signal = DW'(AMP);
        repeat (3) @(negedge clk);
        check("rst bit_out",    bus.bit_out,    0);
        check("rst bit_valid",  bus.bit_valid,  0);
        check("rst data_out",   bus.data_out,   0);
        check("rst frame_done", bus.frame_done, 0);
        check("rst busy",       bus.busy,       0);
        rst_n = 1'b1;
        idle(0, 2);

        // Mixed frame: 1,0,1,0 with a zero-correlation last symbol
        clear_log();
        drive(1, AMP); t = edge_n + 1;
        drive_sym(0, 200, 200, 56, 56);
        drive_sym(0, 56, 56, 200, 200);
        drive_sym(0, 200, 200, 56, 56);
        drive_sym(0, 128, 128, 128, 128);
        idle(0, 4);
        check_frame("f1010", t, 4'b1010);

        // Full-scale samples with sync held high throughout and afterwards
        clear_log();
        drive(1, AMP); t = edge_n + 1;
        for (int i = 0; i < PL; i++) drive_sym(1, 255, 255, 0, 0);
        idle(1, 12);
        check_frame("f1111", t, 4'hF);
        check("held sync busy", bus.busy, 0);

        // Sync must drop and rise again before the next frame
        clear_log();
        drive(0, AMP);
        drive(1, AMP); t = edge_n + 1;
        drive_sym(0, 200, 200, 56, 56);
        drive_sym(0, 56, 56, 200, 200);
        drive_sym(0, 56, 56, 200, 200);
        drive_sym(0, 200, 200, 56, 56);
        idle(0, 4);
        check_frame("f1001", t, 4'b1001);

        // Reset after two symbols, with sync asserted in the reset cycle
        clear_log();
        drive(1, AMP);
        drive_sym(0, 200, 200, 56, 56);
        drive_sym(0, 56, 56, 200, 200);
        @(negedge clk);
        rst_n = 1'b0; bus.sync = 1'b1; bus.signal = DW'(AMP);
        @(negedge clk);
        check("midrst bit_out",    bus.bit_out,    0);
        check("midrst bit_valid",  bus.bit_valid,  0);
        check("midrst data_out",   bus.data_out,   0);
        check("midrst frame_done", bus.frame_done, 0);
        check("midrst busy",       bus.busy,       0);
        rst_n = 1'b1; bus.sync = 1'b0;
        idle(0, 20);
        check("midrst no done", done_cyc.size(), 0);
        clear_log();
        drive(1, AMP); t = edge_n + 1;
        drive_sym(0, 200, 200, 56, 56);
        drive_sym(0, 200, 200, 56, 56);
        drive_sym(0, 56, 56, 200, 200);
        drive_sym(0, 200, 200, 56, 56);
        idle(0, 4);
        check_frame("f1101", t, 4'b1101);

        // Sync drops at t+3 mid-frame; frame still completes on time
        clear_log();
        drive(1, AMP); t = edge_n + 1;
        drive(1, 56); drive(1, 56); drive(0, 200); drive(0, 200);
        drive_sym(0, 200, 200, 56, 56);
        drive_sym(0, 56, 56, 200, 200);
        drive_sym(0, 56, 56, 200, 200);
        idle(0, 4);
        check_frame("f0100", t, 4'b0100);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
